// File: rtl/data_ram_wb_if.sv
// Bus bundle for data_ram_wb: CPU load/store port plus loader port.
// master = CPU/loader side, slave = memory responder.
interface data_ram_wb_if #(
    parameter int ADDR_W = 30
);
    logic              i_ramReadEnable;
    logic              i_ramWriteEnable;
    logic [ADDR_W-1:0] i_ramAddr;
    logic [3:0]        i_ramSel;
    logic [31:0]       i_ramStoreData;
    logic [31:0]       o_ramLoadData;
    logic              i_ldValid;
    logic              o_ldReady;
    logic [ADDR_W-1:0] i_ldAddr;
    logic [31:0]       i_ldData;

    modport master (
        output i_ramReadEnable, i_ramWriteEnable, i_ramAddr,
        output i_ramSel, i_ramStoreData,
        output i_ldValid, i_ldAddr, i_ldData,
        input  o_ramLoadData, o_ldReady
    );

    modport slave (
        input  i_ramReadEnable, i_ramWriteEnable, i_ramAddr,
        input  i_ramSel, i_ramStoreData,
        input  i_ldValid, i_ldAddr, i_ldData,
        output o_ramLoadData, o_ldReady
    );
endinterface

// File: rtl/data_ram_wb.sv
// Data RAM with posted CPU store buffer and a loader write port.
// Ports: clk, rst (async active-low), bus (data_ram_wb_if.slave),
// o_addrErr (sticky, only with DATA_RAM_ADDR_CHECK_EN defined).
module data_ram_wb #(
    parameter int DEPTH_LOG2 = 10,
    parameter int ADDR_W     = 30,
    parameter int WB_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    data_ram_wb_if.slave  bus
`ifdef DATA_RAM_ADDR_CHECK_EN
    ,
    output logic          o_addrErr
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LD_LIMIT = CNT_W'(WB_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WB_DEPTH);

    typedef logic [DEPTH_LOG2-1:0] idx_t;

    logic [31:0] mem [DEPTH];

    idx_t        wbAddr [WB_DEPTH];
    logic [3:0]  wbSel  [WB_DEPTH];
    logic [31:0] wbData [WB_DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic push;
    logic ldGrant;
    logic drain;
    idx_t ramIdx;
    idx_t ldIdx;

    assign ramIdx = bus.i_ramAddr[DEPTH_LOG2-1:0];
    assign ldIdx  = bus.i_ldAddr[DEPTH_LOG2-1:0];

    // Stores with no lanes selected never enter the buffer.
    assign push = bus.i_ramWriteEnable & (bus.i_ramSel != 4'b0000);

    // One slot is always kept free so a push can land in a cycle
    // where the loader owns the array write port.
    assign bus.o_ldReady = rst & (count < LD_LIMIT);
    assign ldGrant       = bus.i_ldValid & bus.o_ldReady;
    assign drain         = ~ldGrant & (count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            unique case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry payload needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            wbAddr[tail] <= ramIdx;
            wbSel[tail]  <= bus.i_ramSel;
            wbData[tail] <= bus.i_ramStoreData;
        end
    end

    // Single array write port: loader first, else drain the head.
    always_ff @(posedge clk) begin
        if (ldGrant) begin
            mem[ldIdx] <= bus.i_ldData;
        end else if (drain) begin
            for (int b = 0; b < 4; b++) begin
                if (wbSel[head][b]) begin
                    mem[wbAddr[head]][8*b +: 8] <= wbData[head][8*b +: 8];
                end
            end
        end
    end

    // Overlay pending stores oldest to newest so newer bytes win.
    logic [31:0]      merged;
    logic [PTR_W-1:0] slot;

    always_comb begin
        merged = mem[ramIdx];
        slot   = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (wbAddr[slot] == ramIdx)) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbSel[slot][b]) begin
                        merged[8*b +: 8] = wbData[slot][8*b +: 8];
                    end
                end
            end
        end
        bus.o_ramLoadData = (rst & bus.i_ramReadEnable) ? merged : 32'h0;
    end

    countNeverFull: assert property (
        @(posedge clk) disable iff (!rst) count < CNT_MAX
    );

`ifdef DATA_RAM_ADDR_CHECK_EN
    logic ramHi;
    logic ldHi;

    assign ramHi = |bus.i_ramAddr[ADDR_W-1:DEPTH_LOG2];
    assign ldHi  = |bus.i_ldAddr[ADDR_W-1:DEPTH_LOG2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_addrErr <= 1'b0;
        end else if (((bus.i_ramReadEnable | bus.i_ramWriteEnable) & ramHi)
                     | (ldGrant & ldHi)) begin
            o_addrErr <= 1'b1;
        end
    end
`else
    logic unusedAddrHi;
    assign unusedAddrHi = ^{bus.i_ramAddr[ADDR_W-1:DEPTH_LOG2],
                            bus.i_ldAddr[ADDR_W-1:DEPTH_LOG2]};
`endif

endmodule

// File: tb/tb_data_ram_wb.sv
// Randomized bench for data_ram_wb against a queue-based memory model.
// Define DATA_RAM_ADDR_CHECK_EN to also exercise o_addrErr.
module tb_data_ram_wb;
    localparam int WB_DEPTH = 4;

    logic clk;
    logic rst;
`ifdef DATA_RAM_ADDR_CHECK_EN
    logic addrErr;
`endif

    data_ram_wb_if #(.ADDR_W(30)) bus ();

    data_ram_wb #(
        .DEPTH_LOG2(10),
        .ADDR_W(30),
        .WB_DEPTH(WB_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef DATA_RAM_ADDR_CHECK_EN
        ,
        .o_addrErr(addrErr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0]  a;
        logic [3:0]  s;
        logic [31:0] d;
    } entry_t;

    logic [31:0] mMem [0:1023];
    entry_t      q[$];
    logic        mErr;
    logic [31:0] lastLoad;
    logic        lastReady;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lanes(logic [31:0] old,
                                          logic [3:0] s, logic [31:0] d);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] expRead(logic re, logic [29:0] a);
        logic [31:0] v;
        if (!re) return 32'h0;
        v = mMem[a[9:0]];
        foreach (q[i])
            if (q[i].a == a[9:0]) v = lanes(v, q[i].s, q[i].d);
        return v;
    endfunction

    // One bus cycle: drive, check combinational outputs, then advance model.
    task automatic step(input logic re, input logic we,
                        input logic [29:0] a, input logic [3:0] s,
                        input logic [31:0] sd, input logic ldv,
                        input logic [29:0] la, input logic [31:0] ld);
        logic grant;
        entry_t e;
        bus.i_ramReadEnable  = re;
        bus.i_ramWriteEnable = we;
        bus.i_ramAddr        = a;
        bus.i_ramSel         = s;
        bus.i_ramStoreData   = sd;
        bus.i_ldValid        = ldv;
        bus.i_ldAddr         = la;
        bus.i_ldData         = ld;
        @(negedge clk);
        lastReady = bus.o_ldReady;
        lastLoad  = bus.o_ramLoadData;
        chk("ldReady", {31'b0, bus.o_ldReady},
            {31'b0, q.size() < WB_DEPTH - 1});
        chk("load", bus.o_ramLoadData, expRead(re, a));
`ifdef DATA_RAM_ADDR_CHECK_EN
        chk("addrErr", {31'b0, addrErr}, {31'b0, mErr});
`endif
        @(posedge clk);
        grant = ldv && (q.size() < WB_DEPTH - 1);
        if (((re || we) && a[29:10] != 0) || (grant && la[29:10] != 0))
            mErr = 1'b1;
        if (grant) begin
            mMem[la[9:0]] = ld;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            mMem[e.a] = lanes(mMem[e.a], e.s, e.d);
        end
        if (we && s != 4'b0) begin
            e.a = a[9:0];
            e.s = s;
            e.d = sd;
            q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ldw(logic [29:0] a, logic [31:0] d);
        step(0, 0, 0, 0, 0, 1, a, d);
    endtask

    task automatic st(logic [29:0] a, logic [3:0] s, logic [31:0] d,
                      logic ldv, logic [29:0] la);
        step(0, 1, a, s, d, ldv, la, $urandom);
    endtask

    task automatic rd(string tag, logic [29:0] a, logic [31:0] exp,
                      logic ldv, logic [29:0] la);
        step(1, 0, a, 0, 0, ldv, la, $urandom);
        chk(tag, lastLoad, exp);
    endtask

    initial begin
        logic [31:0] d;
        int op;
        mErr = 1'b0;
        rst  = 1'b0;
        bus.i_ramReadEnable  = 1'b1;
        bus.i_ramWriteEnable = 1'b0;
        bus.i_ramAddr        = 30'd5;
        bus.i_ramSel         = 4'b0;
        bus.i_ramStoreData   = 32'h0;
        bus.i_ldValid        = 1'b1;
        bus.i_ldAddr         = 30'd0;
        bus.i_ldData         = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        chk("rstReady", {31'b0, bus.o_ldReady}, 32'h0);
        chk("rstLoad", bus.o_ramLoadData, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        bus.i_ldValid        = 1'b0;
        bus.i_ramReadEnable  = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            case (i)
                3: d = 32'hCAFEF00D;
                4: d = 32'h0;
                5: d = 32'h11223344;
                7: d = 32'hAAAAAAAA;
                default: ;
            endcase
            ldw(30'(i), d);
        end

        rd("ldRead5", 5, 32'h11223344, 0, 0);

        for (int i = 0; i < 3; i++) st(5, 4'b0011, 32'h0000BEEF, 1, 15);
        step(0, 0, 0, 0, 0, 1, 15, $urandom);
        chk("fullReady", {31'b0, lastReady}, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 15, $urandom);
        idle(6);
        rd("drain5", 5, 32'h1122BEEF, 0, 0);

        st(7, 4'b1000, 32'h12000000, 1, 14);
        st(7, 4'b0001, 32'h00000034, 1, 14);
        rd("merge7", 7, 32'h12AAAA34, 1, 14);
        idle(6);

        st(9, 4'b1111, 32'h01020304, 0, 0);
        st(9, 4'b0010, 32'h0000FF00, 0, 0);
        rd("merge9", 9, 32'h0102FF04, 0, 0);
        idle(6);
        rd("drained9", 9, 32'h0102FF04, 0, 0);

        st(3, 4'b0000, 32'h55555555, 0, 0);
        chk("sel0Ready", {31'b0, lastReady}, 32'h1);
        rd("sel0Read", 3, 32'hCAFEF00D, 0, 0);

        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 2);
            step(op == 1, op == 2, 30'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0) ? 4'b0 : 4'($urandom),
                 $urandom, ($urandom_range(0, 9) < 4),
                 30'($urandom_range(0, 15)), $urandom);
        end
        idle(6);

        ldw(4, 32'h0);
        st(4, 4'b1111, 32'hDEADBEEF, 1, 15);
        st(4, 4'b0100, 32'h00770000, 1, 15);
        rd("pend4", 4, 32'hDE77BEEF, 1, 15);
        bus.i_ldValid        = 1'b0;
        bus.i_ramReadEnable  = 1'b1;
        bus.i_ramAddr        = 30'd4;
        rst = 1'b0;
        #2;
        chk("midRstLoad", bus.o_ramLoadData, 32'h0);
        chk("midRstReady", {31'b0, bus.o_ldReady}, 32'h0);
        q.delete();
        mErr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd("afterRst4", 4, 32'h0, 0, 0);
        chk("afterRstReady", {31'b0, lastReady}, 32'h1);

`ifdef DATA_RAM_ADDR_CHECK_EN
        rd("hiAddr", 30'h400, mMem[0], 0, 0);
        idle(1);
        chk("addrErrSet", {31'b0, addrErr}, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
